// File: rtl/wb_port_arbiter_if.sv
// Bundles the Write-stage, MDU and regfile write-port signals around the arbiter.
// The arbiter uses the slave modport. The environment that drives the pipe/MDU
// side and observes the regfile side uses the master modport.
interface wb_port_arbiter_if;
  logic        pipe_regwr;
  logic [4:0]  pipe_rw;
  logic [31:0] pipe_busW;
  logic        mdu_valid;
  logic [4:0]  mdu_rw;
  logic [31:0] mdu_result;
  logic        mdu_ready;
  logic        rf_regwr;
  logic [4:0]  rf_rw;
  logic [31:0] rf_busW;
  logic        stall_req;

  modport slave (
    input  pipe_regwr, pipe_rw, pipe_busW,
    input  mdu_valid, mdu_rw, mdu_result,
    output mdu_ready,
    output rf_regwr, rf_rw, rf_busW,
    output stall_req
  );

  modport master (
    output pipe_regwr, pipe_rw, pipe_busW,
    output mdu_valid, mdu_rw, mdu_result,
    input  mdu_ready,
    input  rf_regwr, rf_rw, rf_busW,
    input  stall_req
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// Write-stage writes always take the port. MDU results are queued in a small FIFO
// and written back on cycles when the port is idle. A queued result whose
// destination is overwritten by a newer pipe write is marked dead. A dead entry
// is dropped without a write. If the live head waits too long, stall_req asks
// the pipeline for a write-free bubble.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  wb_port_arbiter_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       rw_q   [DEPTH];
  logic [4:0]       rw_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    age_q, age_d;

  logic pipe_live;
  logic head_present;
  logic head_live;
  logic full;
  logic push;
  logic grant_head;
  logic pop;

  // Decode the pipe write, the FIFO status, and the push/pop decisions for this cycle.
  always_comb begin
    pipe_live    = bus.pipe_regwr & (bus.pipe_rw != 5'd0);
    head_present = (count_q != '0);
    head_live    = head_present & live_q[rd_ptr_q];
    full         = (count_q == CW'(DEPTH));
    // Ready comes from registered occupancy only.
    // A pop in the same cycle does not make room until the next cycle.
    push         = bus.mdu_valid & ~full & ~reset;
    grant_head   = ~pipe_live & head_live;
    // A dead head is dropped even while the pipe is using the port.
    pop          = head_present & (grant_head | ~head_live);
  end

  // Write-port mux. The pipe has priority. Otherwise a live FIFO head is written.
  always_comb begin
    bus.rf_regwr  = 1'b0;
    bus.rf_rw     = 5'd0;
    bus.rf_busW   = 32'd0;
    bus.mdu_ready = ~full & ~reset;
    bus.stall_req = ~reset & head_live & (age_q >= AW'(STARVE_LIMIT));
    if (!reset) begin
      if (pipe_live) begin
        bus.rf_regwr = 1'b1;
        bus.rf_rw    = bus.pipe_rw;
        bus.rf_busW  = bus.pipe_busW;
      end else if (head_live) begin
        bus.rf_regwr = 1'b1;
        bus.rf_rw    = rw_q[rd_ptr_q];
        bus.rf_busW  = data_q[rd_ptr_q];
      end
    end
  end

  // Next FIFO contents, pointers, occupancy and head age.
  always_comb begin
    live_d   = live_q;
    rw_d     = rw_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    age_d    = age_q;

    // WAW squash. The newer pipe write kills older queued results for the same
    // register. Unoccupied slots may be cleared too; push rewrites their live bit.
    if (pipe_live) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rw_q[i] == bus.pipe_rw) live_d[i] = 1'b0;
      end
    end

    // The entry pushed this cycle is newer than the pipe write, so it overrides the squash.
    if (push) begin
      live_d[wr_ptr_q] = (bus.mdu_rw != 5'd0);
      rw_d[wr_ptr_q]   = bus.mdu_rw;
      data_d[wr_ptr_q] = bus.mdu_result;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Age counts only while a live head is blocked. The counter saturates at the limit.
    if (pop || !head_present) begin
      age_d = '0;
    end else if (age_q != AW'(STARVE_LIMIT)) begin
      age_d = age_q + AW'(1);
    end
  end

  // State registers with synchronous reset. Reset discards all buffered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rw_q[i]   <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      live_q   <= live_d;
      rw_q     <= rw_d;
      data_q   <= data_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter.
// First, a table of hand-derived directed cycles is applied.
// Then randomized traffic runs against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  wb_port_arbiter_if bus_if ();

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pwr;
    logic [4:0]  prw;
    logic [31:0] pbus;
    logic        mv;
    logic [4:0]  mrw;
    logic [31:0] mres;
    logic        e_ready;
    logic        e_wr;
    logic [4:0]  e_rw;
    logic [31:0] e_bus;
    logic        e_stall;
  } vec_t;

  typedef struct {
    bit          live;
    logic [4:0]  rw;
    logic [31:0] data;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];
  int   m_age;
  int   vectors = 0;
  int   miscompares = 0;

  logic        m_ready, m_wr, m_stall;
  logic [4:0]  m_rw;
  logic [31:0] m_bus;

  // Reference outputs are derived from the queue view of the buffered results.
  task automatic model_outputs(input logic rst, pwr, input logic [4:0] prw, input logic [31:0] pbus);
    bit pl, hl;
    pl = pwr && (prw != 0);
    hl = (mq.size() > 0) && mq[0].live;
    m_ready = !rst && (mq.size() < DEPTH);
    m_stall = !rst && hl && (m_age >= LIMIT);
    m_wr = 0; m_rw = 0; m_bus = 0;
    if (!rst) begin
      if (pl) begin
        m_wr = 1; m_rw = prw; m_bus = pbus;
      end else if (hl) begin
        m_wr = 1; m_rw = mq[0].rw; m_bus = mq[0].data;
      end
    end
  endtask

  task automatic model_update(input logic rst, pwr, input logic [4:0] prw,
                              input logic mv, input logic [4:0] mrw, input logic [31:0] mres);
    bit pl, hl, pop, acc;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_age = 0;
      return;
    end
    pl  = pwr && (prw != 0);
    hl  = (mq.size() > 0) && mq[0].live;
    pop = (mq.size() > 0) && (!pl || !hl);
    acc = mv && (mq.size() < DEPTH);
    if (pop || mq.size() == 0) m_age = 0;
    else if (m_age < LIMIT) m_age++;
    if (pl) foreach (mq[i]) if (mq[i].rw == prw) mq[i].live = 0;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      e.live = (mrw != 0); e.rw = mrw; e.data = mres;
      mq.push_back(e);
    end
  endtask

  task automatic compare(input string name, input logic er, ew, input logic [4:0] erw,
                         input logic [31:0] eb, input logic es);
    vectors++;
    if (bus_if.mdu_ready !== er || bus_if.rf_regwr !== ew || bus_if.rf_rw !== erw ||
        bus_if.rf_busW !== eb || bus_if.stall_req !== es) begin
      miscompares++;
      $display("FAIL %s t=%0t got ready=%b wr=%b rw=%0d busW=%0d stall=%b expected ready=%b wr=%b rw=%0d busW=%0d stall=%b",
               name, $time, bus_if.mdu_ready, bus_if.rf_regwr, bus_if.rf_rw, bus_if.rf_busW,
               bus_if.stall_req, er, ew, erw, eb, es);
    end
  endtask

  // One clock cycle: drive inputs, check mid-cycle, advance the model, then cross the edge.
  task automatic step(input string name, input logic rst, pwr, input logic [4:0] prw,
                      input logic [31:0] pbus, input logic mv, input logic [4:0] mrw,
                      input logic [31:0] mres);
    reset             = rst;
    bus_if.pipe_regwr = pwr;
    bus_if.pipe_rw    = prw;
    bus_if.pipe_busW  = pbus;
    bus_if.mdu_valid  = mv;
    bus_if.mdu_rw     = mrw;
    bus_if.mdu_result = mres;
    #4;
    model_outputs(rst, pwr, prw, pbus);
    compare(name, m_ready, m_wr, m_rw, m_bus, m_stall);
    model_update(rst, pwr, prw, mv, mrw, mres);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, pwr, input logic [4:0] prw, input logic [31:0] pbus,
                     input logic mv, input logic [4:0] mrw, input logic [31:0] mres,
                     input logic er, ew, input logic [4:0] erw, input logic [31:0] eb, input logic es);
    vec_t v;
    v = '{rst, pwr, prw, pbus, mv, mrw, mres, er, ew, erw, eb, es};
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic last_stall;
    reset = 1'b1;
    bus_if.pipe_regwr = 0; bus_if.pipe_rw = 0; bus_if.pipe_busW = 0;
    bus_if.mdu_valid = 0; bus_if.mdu_rw = 0; bus_if.mdu_result = 0;
    m_age = 0;

    //   rst pwr prw pbus mv mrw mres | rdy wr rw bus stall
    add(1, 0, 0, 0,   0, 0,  0,    0, 0, 0, 0,   0);  // reset
    add(1, 0, 0, 0,   0, 0,  0,    0, 0, 0, 0,   0);
    add(0, 1, 1, 3,   0, 0,  0,    1, 1, 1, 3,   0);  // pipe passthrough
    add(0, 1, 0, 3,   0, 0,  0,    1, 0, 0, 0,   0);  // r0 write dropped
    add(0, 0, 0, 0,   1, 5,  42,   1, 0, 0, 0,   0);  // push, no bypass
    add(0, 0, 0, 0,   0, 0,  0,    1, 1, 5, 42,  0);  // drain
    add(0, 0, 0, 0,   0, 0,  0,    1, 0, 0, 0,   0);
    add(0, 1, 1, 100, 1, 6,  60,   1, 1, 1, 100, 0);  // starvation
    add(0, 1, 1, 100, 1, 7,  70,   1, 1, 1, 100, 0);
    add(0, 1, 1, 100, 0, 0,  0,    0, 1, 1, 100, 0);  // full
    add(0, 1, 1, 100, 0, 0,  0,    0, 1, 1, 100, 0);
    add(0, 1, 1, 100, 0, 0,  0,    0, 1, 1, 100, 0);
    add(0, 1, 1, 100, 0, 0,  0,    0, 1, 1, 100, 1);  // stall after 4 waits
    add(0, 0, 0, 0,   0, 0,  0,    0, 1, 6, 60,  1);
    add(0, 0, 0, 0,   0, 0,  0,    1, 1, 7, 70,  0);
    add(0, 0, 0, 0,   0, 0,  0,    1, 0, 0, 0,   0);
    add(0, 0, 0, 0,   1, 9,  1,    1, 0, 0, 0,   0);  // WAW squash
    add(0, 1, 9, 2,   0, 0,  0,    1, 1, 9, 2,   0);
    add(0, 0, 0, 0,   0, 0,  0,    1, 0, 0, 0,   0);  // dead head popped
    add(0, 0, 0, 0,   0, 0,  0,    1, 0, 0, 0,   0);
    add(0, 0, 0, 0,   1, 0,  8,    1, 0, 0, 0,   0);  // push to r0
    add(0, 0, 0, 0,   0, 0,  0,    1, 0, 0, 0,   0);
    add(0, 0, 0, 0,   0, 0,  0,    1, 0, 0, 0,   0);
    add(0, 1, 2, 7,   1, 11, 5,    1, 1, 2, 7,   0);  // reset discards
    add(0, 1, 2, 7,   1, 12, 6,    1, 1, 2, 7,   0);
    add(1, 1, 2, 7,   0, 0,  0,    0, 0, 0, 0,   0);
    add(0, 0, 0, 0,   0, 0,  0,    1, 0, 0, 0,   0);
    add(0, 0, 0, 0,   0, 0,  0,    1, 0, 0, 0,   0);

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      reset             = v.rst;
      bus_if.pipe_regwr = v.pwr;
      bus_if.pipe_rw    = v.prw;
      bus_if.pipe_busW  = v.pbus;
      bus_if.mdu_valid  = v.mv;
      bus_if.mdu_rw     = v.mrw;
      bus_if.mdu_result = v.mres;
      #4;
      compare($sformatf("table[%0d]", i), v.e_ready, v.e_wr, v.e_rw, v.e_bus, v.e_stall);
      model_update(v.rst, v.pwr, v.prw, v.mv, v.mrw, v.mres);
      @(posedge clk);
      #1;
    end

    // The random phase mostly honours stall_req, but sometimes ignores it to hold the head at saturation.
    last_stall = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r, pw, mv;
      logic [4:0] prw, mrw;
      r   = ($urandom_range(0, 149) == 0);
      pw  = (last_stall && $urandom_range(0, 9) != 0) ? 1'b0 : 1'($urandom_range(0, 1));
      prw = 5'($urandom_range(0, 7));
      mv  = 1'($urandom_range(0, 1));
      mrw = 5'($urandom_range(0, 7));
      model_outputs(r, pw, prw, 32'd0);
      last_stall = m_stall;
      step($sformatf("random[%0d]", n), r, pw, prw, $urandom, mv, mrw, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
